// File: rtl/lbm_pkg.sv
// Shared constants, lane order and FSM state encoding for the LBM BRAM scheduler.
package lbm_pkg;

   localparam int unsigned NUM_DIR        = 9;
   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned STREAM_WIDTH   = NUM_DIR * DATA_WIDTH_DEF;

   // D2Q9 lane index within a stream word, counted from the LSB
   localparam int unsigned LANE_NULL = 0;
   localparam int unsigned LANE_N    = 1;
   localparam int unsigned LANE_NE   = 2;
   localparam int unsigned LANE_E    = 3;
   localparam int unsigned LANE_SE   = 4;
   localparam int unsigned LANE_S    = 5;
   localparam int unsigned LANE_SW   = 6;
   localparam int unsigned LANE_W    = 7;
   localparam int unsigned LANE_NW   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   function automatic int unsigned stream_width(input int unsigned dw);
      return NUM_DIR * dw;
   endfunction

endpackage

// File: rtl/lbm_bram_scheduler_if.sv
// AXI4-Stream master bundle carrying one nine-lane lattice cell per beat.
interface lbm_bram_scheduler_if
   import lbm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16
);
   localparam int unsigned SW = stream_width(DATA_WIDTH);

   logic          tvalid;
   logic          tready;
   logic [SW-1:0] tdata;
   logic [SW/8-1:0] tstrb;
   logic          tlast;

   modport master (output tvalid, tdata, tstrb, tlast, input tready);
   modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/lbm_skid_fifo.sv
// Two-entry FIFO that absorbs RAM read data while the stream consumer stalls.
module lbm_skid_fifo #(
   parameter int unsigned WIDTH = 144
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

   assign data  = mem_q[rd_ptr_q];
   assign valid = (count_q != 2'd0);
   assign count = count_q;
endmodule

// File: rtl/lbm_bram_scheduler.sv
// Shares one port of the nine direction RAMs between collision write-back and frame readout
// to AXI4-Stream. Define LBM_WR_FAIRNESS_EN to alternate write/read grants during readout.
module lbm_bram_scheduler
   import lbm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned DEPTH         = 2500,
   parameter int unsigned ADDRESS_WIDTH = 12
) (
   input  logic                                m00_axis_aclk,
   input  logic                                m00_axis_areset,
   input  logic                                frame_ready,
   input  logic                                wr_req,
   input  logic [ADDRESS_WIDTH-1:0]            wr_addr,
   input  logic [stream_width(DATA_WIDTH)-1:0] wr_data,
   output logic                                wr_gnt,
   output logic [ADDRESS_WIDTH-1:0]            ram_addr,
   output logic                                ram_we,
   output logic [stream_width(DATA_WIDTH)-1:0] ram_wdata,
   input  logic [stream_width(DATA_WIDTH)-1:0] ram_rdata,
   output logic                                busy,
   lbm_bram_scheduler_if.master                m00_axis
);
   localparam int unsigned SW = stream_width(DATA_WIDTH);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] rd_addr_q;
   logic [ADDRESS_WIDTH-1:0] out_cnt_q;
   logic                     inflight_q;
   logic                     rd_want, rd_issue, wr_win, space, pop, last_rd, tlast;
   logic                     fifo_valid;
   logic [1:0]               fifo_count;
   logic [SW-1:0]            fifo_data;

   assign pop     = fifo_valid && m00_axis.tready;
   assign last_rd = (rd_addr_q == LAST_ADDR);
   assign tlast   = fifo_valid && (out_cnt_q == LAST_ADDR);

   // Occupancy is judged after this cycle's pop so a free-flowing stream never bubbles
   assign space   = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
   assign rd_want = space && ((state_q == ST_IDLE && frame_ready) || state_q == ST_READ);

`ifdef LBM_WR_FAIRNESS_EN
   logic wr_turn_q;
   assign wr_win = wr_req && (!(rd_want && state_q == ST_READ) || wr_turn_q);

   // Write owns the first contention of each frame, then ownership alternates
   always_ff @(posedge m00_axis_aclk) begin
      if (m00_axis_areset || state_q == ST_IDLE) wr_turn_q <= 1'b1;
      else if (state_q == ST_READ && wr_req && rd_want) wr_turn_q <= ~wr_turn_q;
   end
`else
   assign wr_win = wr_req;
`endif

   always_comb begin
      state_d   = state_q;
      wr_gnt    = 1'b0;
      rd_issue  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = rd_addr_q;
      ram_wdata = '0;
      if (!m00_axis_areset) begin
         wr_gnt   = wr_win;
         rd_issue = rd_want && !wr_win;
      end
      if (wr_gnt) begin
         ram_we    = 1'b1;
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end
      case (state_q)
         ST_IDLE:  if (frame_ready) state_d = (rd_issue && last_rd) ? ST_DRAIN : ST_READ;
         ST_READ:  if (rd_issue && last_rd) state_d = ST_DRAIN;
         ST_DRAIN: if (pop && tlast) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge m00_axis_aclk) begin
      if (m00_axis_areset) begin
         state_q    <= ST_IDLE;
         rd_addr_q  <= '0;
         out_cnt_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rd_issue;
         if (state_d == ST_IDLE) rd_addr_q <= '0;
         else if (rd_issue && !last_rd) rd_addr_q <= rd_addr_q + ADDRESS_WIDTH'(1);
         if (pop) out_cnt_q <= tlast ? '0 : out_cnt_q + ADDRESS_WIDTH'(1);
      end
   end

   lbm_skid_fifo #(.WIDTH(SW)) u_fifo (
      .clk       (m00_axis_aclk),
      .rst       (m00_axis_areset),
      .push      (inflight_q),
      .push_data (ram_rdata),
      .pop       (pop),
      .data      (fifo_data),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign busy           = (state_q != ST_IDLE);
   assign m00_axis.tvalid = fifo_valid;
   assign m00_axis.tdata  = fifo_data;
   assign m00_axis.tlast  = tlast;
   assign m00_axis.tstrb  = '1;
endmodule

// File: tb/tb_lbm_bram_scheduler.sv
// Scoreboard bench: directed frames against a registered-read RAM model, DEPTH=4.
module tb_lbm_bram_scheduler;
   import lbm_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned SW = NUM_DIR * DW;

   typedef struct {
      logic [SW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_ready = 1'b0;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [SW-1:0] wr_data = '0;
   logic          wr_gnt, ram_we, busy;
   logic [AW-1:0] ram_addr;
   logic [SW-1:0] ram_wdata;
   logic [SW-1:0] ram_rdata;
   logic [SW-1:0] ram [16];
   logic          ram_loaded = 1'b0;
   logic [SW-1:0] pat_a;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   beat_t         exp_q[$];
   int            beat_cyc[$];
   logic          cell2_new = 1'b0;

   lbm_bram_scheduler_if #(.DATA_WIDTH(DW)) axis ();

   lbm_bram_scheduler #(.DATA_WIDTH(DW), .DEPTH(4), .ADDRESS_WIDTH(AW)) dut (
      .m00_axis_aclk   (clk),
      .m00_axis_areset (rst),
      .frame_ready     (frame_ready),
      .wr_req          (wr_req),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .wr_gnt          (wr_gnt),
      .ram_addr        (ram_addr),
      .ram_we          (ram_we),
      .ram_wdata       (ram_wdata),
      .ram_rdata       (ram_rdata),
      .busy            (busy),
      .m00_axis        (axis)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [SW-1:0] cell_word(input int i);
      logic [SW-1:0] w;
      for (int k = 0; k < int'(NUM_DIR); k++) w[k*DW +: DW] = 16'(32'h1000 + i * 16 + k);
      return w;
   endfunction

   function automatic logic [SW-1:0] exp_cell(input int i);
      return (i == 2 && cell2_new) ? {9{16'hAAAA}} : cell_word(i);
   endfunction

   // Single-port RAM with one-cycle registered read (read-before-write)
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 16; i++) ram[i] <= cell_word(i);
         ram_loaded <= 1'b1;
      end else if (ram_we) begin
         ram[ram_addr] <= ram_wdata;
      end
      ram_rdata <= ram[ram_addr];
   end

   task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      for (int i = 0; i < 4; i++) exp_q.push_back('{data: exp_cell(i), last: (i == 3)});
   endtask

   task automatic pulse_frame(output int c0);
      frame_ready = 1'b1;
      c0 = cyc;
      step();
      frame_ready = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 60) begin
         step();
         n++;
      end
      checks++;
      if (n >= 60) begin
         errors++;
         $display("FAIL %s_timeout: pending=%0d busy=%0b required pending=0 busy=0", name, exp_q.size(), busy);
      end
      repeat (3) step();
   endtask

   // Monitor: pops expectations on every accepted beat and checks hold-while-stalled
   logic          prev_stall = 1'b0;
   logic [SW-1:0] held_data;
   logic          held_last;
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!axis.tvalid || axis.tdata !== held_data || axis.tlast !== held_last) begin
               errors++;
               $display("FAIL stall_hold: valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b",
                        axis.tvalid, axis.tdata, axis.tlast, held_data, held_last);
            end
         end
         if (axis.tvalid && axis.tready) begin
            beat_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got %h required no beat", axis.tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", axis.tdata, e.data);
               chk("beat_last", SW'(axis.tlast), SW'(e.last));
               chk("beat_strb", SW'(axis.tstrb), SW'(18'h3FFFF));
            end
         end
         prev_stall = axis.tvalid && !axis.tready;
         held_data  = axis.tdata;
         held_last  = axis.tlast;
      end
   end

   initial begin
      int c0;
      logic [2:0] exp_g;
      int exp_b1;
      pat_a = {9{16'hAAAA}};
      axis.tready = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", SW'(axis.tvalid), '0);
      chk("rst_tlast", SW'(axis.tlast), '0);
      chk("rst_busy", SW'(busy), '0);
      chk("rst_wr_gnt", SW'(wr_gnt), '0);
      chk("rst_ram_we", SW'(ram_we), '0);
      chk("rst_tdata", axis.tdata, '0);
      step();

      // Free-running frame: four back-to-back beats two cycles after frame_ready
      beat_cyc.delete();
      push_frame();
      pulse_frame(c0);
      repeat (4) step();
      @(negedge clk);
      chk("busy_last_beat", SW'(busy), SW'(1));
      step();
      @(negedge clk);
      chk("busy_after_frame", SW'(busy), '0);
      chk("beat_count", SW'(beat_cyc.size()), SW'(4));
      for (int i = 0; i < 4 && i < beat_cyc.size(); i++)
         chk("beat_cycle", SW'(beat_cyc[i]), SW'(c0 + 2 + i));
      wait_idle("frame1");

      // Consumer stalls for five cycles mid-frame
      push_frame();
      pulse_frame(c0);
      step();
      axis.tready = 1'b0;
      repeat (5) step();
      axis.tready = 1'b1;
      wait_idle("stall");

      // Write-back contention during readout
      cell2_new = 1'b1;
      beat_cyc.delete();
      push_frame();
      pulse_frame(c0);
      wr_req  = 1'b1;
      wr_addr = 4'd2;
      wr_data = pat_a;
`ifdef LBM_WR_FAIRNESS_EN
      exp_g  = 3'b101;
      exp_b1 = c0 + 4;
`else
      exp_g  = 3'b111;
      exp_b1 = c0 + 6;
`endif
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("wr_gnt", SW'(wr_gnt), SW'(exp_g[k]));
         chk("ram_we", SW'(ram_we), SW'(exp_g[k]));
         if (exp_g[k]) chk("ram_addr_wr", SW'(ram_addr), SW'(2));
         step();
      end
      wr_req = 1'b0;
      wait_idle("write");
      chk("ram_cell2", ram[2], pat_a);
      if (beat_cyc.size() > 1) chk("beat1_cycle", SW'(beat_cyc[1]), SW'(exp_b1));
      else chk("beat1_seen", SW'(beat_cyc.size()), SW'(4));

      // Reset while the second beat is on the bus
      exp_q.push_back('{data: exp_cell(0), last: 1'b0});
      pulse_frame(c0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_tvalid", SW'(axis.tvalid), '0);
      chk("mid_rst_tlast", SW'(axis.tlast), '0);
      chk("mid_rst_busy", SW'(busy), '0);
      chk("mid_rst_ram_we", SW'(ram_we), '0);
      chk("mid_rst_tdata", axis.tdata, '0);
      chk("mid_rst_pending", SW'(exp_q.size()), '0);
      step();
      push_frame();
      pulse_frame(c0);
      wait_idle("restart");

      // frame_ready during READ and in the DRAIN exit cycle must be ignored
      beat_cyc.delete();
      push_frame();
      pulse_frame(c0);
      step();
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      step();
      step();
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      repeat (6) step();
      @(negedge clk);
      chk("ignored_busy", SW'(busy), '0);
      chk("ignored_beats", SW'(beat_cyc.size()), SW'(4));
      chk("final_pending", SW'(exp_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
